// File: rtl/cycle_timer_pkg.sv
// Shared types and helpers for the multi-channel cycle timer.
// Imported by timer_channel and multi_cycle_timer.
package cycle_timer_pkg;

    typedef enum logic {
        TIMER_ONESHOT  = 1'b0,
        TIMER_PERIODIC = 1'b1
    } timer_mode_t;

    typedef enum logic {
        TIMER_IDLE    = 1'b0,
        TIMER_RUNNING = 1'b1
    } timer_state_t;

    // A single channel still needs a one-bit select port.
    function automatic int index_width(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/timer_channel.sv
// One timer slice: down-counter, reload value, mode and IDLE/RUNNING state.
// fire is the same-cycle expiry event; expired is its registered copy.
module timer_channel
    import cycle_timer_pkg::*;
#(
    parameter int BIT_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 load,
    input  logic                 cancel,
    input  logic                 enable,
    input  logic                 tick,
    input  logic [BIT_WIDTH-1:0] count,
    input  logic                 mode,
    output logic                 running,
    output logic                 expired,
    output logic                 fire
);

    timer_state_t         state_q, state_n;
    timer_mode_t          mode_q, mode_n;
    logic [BIT_WIDTH-1:0] counter_q, counter_n;
    logic [BIT_WIDTH-1:0] reload_q, reload_n;
    logic                 expired_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= TIMER_IDLE;
            mode_q    <= TIMER_ONESHOT;
            counter_q <= '0;
            reload_q  <= '0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_n;
            mode_q    <= mode_n;
            counter_q <= counter_n;
            reload_q  <= reload_n;
            expired_q <= fire;
        end
    end

    // Load beats cancel beats expiry, so either one swallows a coinciding zero.
    always_comb begin
        state_n   = state_q;
        mode_n    = mode_q;
        counter_n = counter_q;
        reload_n  = reload_q;
        fire      = 1'b0;
        if (load) begin
            state_n   = TIMER_RUNNING;
            mode_n    = timer_mode_t'(mode);
            counter_n = count;
            reload_n  = count;
        end else if (cancel) begin
            state_n = TIMER_IDLE;
        end else if (state_q == TIMER_RUNNING && enable && tick) begin
            if (counter_q != '0) begin
                counter_n = counter_q - BIT_WIDTH'(1);
            end else begin
                fire = 1'b1;
                if (mode_q == TIMER_PERIODIC) begin
                    counter_n = reload_q;
                end else begin
                    state_n = TIMER_IDLE;
                end
            end
        end
    end

    assign running = (state_q == TIMER_RUNNING);
    assign expired = expired_q;

endmodule

// File: rtl/multi_cycle_timer.sv
// CHANNELS independent down-counters with shared load port, sticky status and irq.
// Optional shared tick prescaler enabled by defining CYCLE_TIMER_PRESCALER_EN.
module multi_cycle_timer
    import cycle_timer_pkg::*;
#(
    parameter int  CHANNELS       = 4,
    parameter int  BIT_WIDTH      = 16,
    parameter int  PRESCALE_WIDTH = 8,
    localparam int IDX_W          = index_width(CHANNELS)
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [CHANNELS-1:0]       enable,
    input  logic                      load_valid,
    input  logic [IDX_W-1:0]          load_channel,
    input  logic [BIT_WIDTH-1:0]      load_count,
    input  logic                      load_mode,
    input  logic [CHANNELS-1:0]       cancel,
    input  logic [CHANNELS-1:0]       status_clear,
    input  logic [CHANNELS-1:0]       irq_mask,
`ifdef CYCLE_TIMER_PRESCALER_EN
    input  logic [PRESCALE_WIDTH-1:0] prescale_value,
`endif
    output logic [CHANNELS-1:0]       running,
    output logic [CHANNELS-1:0]       expired,
    output logic [CHANNELS-1:0]       status,
    output logic                      irq
);

    logic                tick;
    logic [31:0]         chan_ext;
    logic [CHANNELS-1:0] load_hit;
    logic [CHANNELS-1:0] fire;
    logic [CHANNELS-1:0] status_q;
    logic                irq_q;

`ifdef CYCLE_TIMER_PRESCALER_EN
    logic [PRESCALE_WIDTH-1:0] prescale_q;

    // Free-running divider; >= keeps it from wrapping if prescale_value shrinks.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            prescale_q <= '0;
        end else if (tick) begin
            prescale_q <= '0;
        end else begin
            prescale_q <= prescale_q + PRESCALE_WIDTH'(1);
        end
    end

    assign tick = (prescale_q >= prescale_value);
`else
    // PRESCALE_WIDTH has no role without the prescaler; counting runs every cycle.
    assign tick = (PRESCALE_WIDTH > 0) || 1'b1;
`endif

    assign chan_ext = 32'(load_channel);

    always_comb begin
        load_hit = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            load_hit[i] = load_valid && (chan_ext == i);
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        timer_channel #(
            .BIT_WIDTH (BIT_WIDTH)
        ) u_channel (
            .clock   (clock),
            .reset_n (reset_n),
            .load    (load_hit[g]),
            .cancel  (cancel[g]),
            .enable  (enable[g]),
            .tick    (tick),
            .count   (load_count),
            .mode    (load_mode),
            .running (running[g]),
            .expired (expired[g]),
            .fire    (fire[g])
        );
    end

    // Set wins over clear; irq follows the registered status one cycle later.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            status_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            status_q <= (status_q & ~status_clear) | fire;
            irq_q    <= |(status_q & irq_mask);
        end
    end

    assign status = status_q;
    assign irq    = irq_q;

endmodule

// File: tb/tb_multi_cycle_timer.sv
// Self-checking bench for multi_cycle_timer: directed literal checks plus
// randomized traffic compared every cycle against an elapsed-tick model.
module tb_multi_cycle_timer;

    localparam int CH = 5;
    localparam int BW = 16;
    localparam int PW = 8;
    localparam int PV = 3;

    logic          clock = 1'b0;
    logic          reset_n;
    logic [CH-1:0] enable;
    logic          load_valid;
    logic [2:0]    load_channel;
    logic [BW-1:0] load_count;
    logic          load_mode;
    logic [CH-1:0] cancel;
    logic [CH-1:0] status_clear;
    logic [CH-1:0] irq_mask;
`ifdef CYCLE_TIMER_PRESCALER_EN
    logic [PW-1:0] prescale_value = PV[PW-1:0];
`endif
    logic [CH-1:0] running;
    logic [CH-1:0] expired;
    logic [CH-1:0] status;
    logic          irq;

    int n_cmp  = 0;
    int n_fail = 0;
    bit check_en = 1'b0;

    multi_cycle_timer #(
        .CHANNELS       (CH),
        .BIT_WIDTH      (BW),
        .PRESCALE_WIDTH (PW)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .enable         (enable),
        .load_valid     (load_valid),
        .load_channel   (load_channel),
        .load_count     (load_count),
        .load_mode      (load_mode),
        .cancel         (cancel),
        .status_clear   (status_clear),
        .irq_mask       (irq_mask),
`ifdef CYCLE_TIMER_PRESCALER_EN
        .prescale_value (prescale_value),
`endif
        .running        (running),
        .expired        (expired),
        .status         (status),
        .irq            (irq)
    );

    always #5 clock = ~clock;

    // Model: a channel expires once it has seen count+1 enabled ticks since load/reload.
    int            m_target  [CH];
    int            m_elapsed [CH];
    bit            m_active  [CH];
    bit            m_periodic[CH];
    int            m_cyc;
    logic [CH-1:0] e_running, e_expired, e_status, m_fire;
    logic          e_irq;
    bit            m_tick;

    always @(posedge clock) begin
        if (!reset_n) begin
            for (int c = 0; c < CH; c++) begin
                m_active[c] = 0; m_periodic[c] = 0; m_target[c] = 1; m_elapsed[c] = 0;
            end
            e_running = '0; e_expired = '0; e_status = '0; e_irq = 1'b0; m_cyc = 0;
        end else begin
            m_tick = 1'b1;
`ifdef CYCLE_TIMER_PRESCALER_EN
            m_tick = ((m_cyc % (PV + 1)) == PV);
            m_cyc++;
`endif
            m_fire = '0;
            for (int c = 0; c < CH; c++) begin
                if (load_valid && int'(load_channel) == c) begin
                    m_active[c]   = 1;
                    m_periodic[c] = load_mode;
                    m_target[c]   = int'(load_count) + 1;
                    m_elapsed[c]  = 0;
                end else if (cancel[c]) begin
                    m_active[c] = 0;
                end else if (m_active[c] && enable[c] && m_tick) begin
                    m_elapsed[c]++;
                    if (m_elapsed[c] == m_target[c]) begin
                        m_fire[c]    = 1'b1;
                        m_elapsed[c] = 0;
                        if (!m_periodic[c]) m_active[c] = 0;
                    end
                end
                e_running[c] = m_active[c];
            end
            e_irq     = |(e_status & irq_mask);
            e_status  = (e_status & ~status_clear) | m_fire;
            e_expired = m_fire;
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (check_en) begin
            check_output("model_running", 32'(running), 32'(e_running));
            check_output("model_expired", 32'(expired), 32'(e_expired));
            check_output("model_status",  32'(status),  32'(e_status));
            check_output("model_irq",     32'(irq),     32'(e_irq));
        end
    end

    task automatic tick_cycle();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic idle_inputs();
        load_valid   = 1'b0;
        cancel       = '0;
        status_clear = '0;
    endtask

    task automatic pulse_load(input int ch, input int n, input bit mode);
        load_valid   = 1'b1;
        load_channel = 3'(ch);
        load_count   = BW'(n);
        load_mode    = mode;
        tick_cycle();
        load_valid   = 1'b0;
    endtask

    // Bounded wait: at = cycles after the load edge of the first pulse, -1 on timeout.
    task automatic measure(input int ch, input int max_cycles, output int at);
        at = -1;
        for (int i = 1; i <= max_cycles; i++) begin
            tick_cycle();
            if (expired[ch]) begin
                at = i;
                break;
            end
        end
    endtask

    task automatic apply_stimulus();
        load_valid   = ($urandom_range(0, 5) == 0);
        load_channel = 3'($urandom_range(0, 7));
        load_count   = BW'($urandom_range(0, 12));
        load_mode    = 1'($urandom_range(0, 1));
        for (int c = 0; c < CH; c++) begin
            cancel[c]       = ($urandom_range(0, 31) == 0);
            enable[c]       = ($urandom_range(0, 7) != 0);
            status_clear[c] = ($urandom_range(0, 7) == 0);
        end
        if ($urandom_range(0, 31) == 0) irq_mask = CH'($urandom);
        reset_n = ($urandom_range(0, 499) != 0);
    endtask

    initial begin
        int at;
        int hits[$];
        int exp_p[6];
        exp_p = '{4, 8, 12, 16, 20, 26};

        reset_n = 1'b0; enable = '1; irq_mask = '1;
        load_channel = '0; load_count = '0; load_mode = 1'b0;
        idle_inputs();
        tick_cycle();
        check_en = 1'b1;
        tick_cycle();
        reset_n = 1'b1;
        check_output("reset_running", 32'(running), 32'h0);
        check_output("reset_expired", 32'(expired), 32'h0);
        check_output("reset_status",  32'(status),  32'h0);
        check_output("reset_irq",     32'(irq),     32'h0);

`ifndef CYCLE_TIMER_PRESCALER_EN
        // One-shot N=5 on ch0.
        pulse_load(0, 5, 1'b0);
        check_output("ch0_running_after_load", 32'(running[0]), 32'h1);
        measure(0, 20, at);
        check_output("ch0_oneshot_latency", at, 32'd6);
        check_output("ch0_running_drops", 32'(running[0]), 32'h0);
        check_output("ch0_status_set", 32'(status[0]), 32'h1);
        check_output("ch0_irq_not_yet", 32'(irq), 32'h0);
        tick_cycle();
        check_output("ch0_irq_next", 32'(irq), 32'h1);
        check_output("ch0_single_pulse", 32'(expired[0]), 32'h0);

        // Periodic N=3 on ch1 with a two-cycle enable gap.
        pulse_load(1, 3, 1'b1);
        for (int i = 1; i <= 27; i++) begin
            tick_cycle();
            if (expired[1]) hits.push_back(i);
            if (i == 20) enable[1] = 1'b0;
            if (i == 22) enable[1] = 1'b1;
        end
        check_output("ch1_pulse_count", hits.size(), 32'd6);
        for (int k = 0; k < 6 && k < hits.size(); k++)
            check_output("ch1_pulse_time", hits[k], exp_p[k]);

        // Load and cancel landing on counter==0 of ch2.
        pulse_load(2, 2, 1'b0);
        tick_cycle(); tick_cycle();
        pulse_load(2, 7, 1'b0);
        check_output("ch2_load_suppresses", 32'(expired[2]), 32'h0);
        measure(2, 20, at);
        check_output("ch2_reload_latency", at, 32'd8);
        pulse_load(2, 2, 1'b0);
        tick_cycle(); tick_cycle();
        cancel[2] = 1'b1;
        tick_cycle();
        cancel = '0;
        check_output("ch2_cancel_suppresses", 32'(expired[2]), 32'h0);
        check_output("ch2_cancel_idle", 32'(running[2]), 32'h0);
        measure(2, 6, at);
        check_output("ch2_no_late_pulse", at, 32'hffff_ffff);

        // Clear colliding with expiry, then masked irq.
        status_clear = '1;
        tick_cycle();
        status_clear = '0;
        check_output("status_cleared", 32'(status[0]), 32'h0);
        pulse_load(0, 1, 1'b0);
        tick_cycle();
        status_clear[0] = 1'b1;
        tick_cycle();
        status_clear = '0;
        check_output("clear_vs_set_pulse", 32'(expired[0]), 32'h1);
        check_output("clear_vs_set_status", 32'(status[0]), 32'h1);
        cancel = '1; irq_mask = '0; status_clear = '1;
        tick_cycle();
        idle_inputs();
        tick_cycle();
        pulse_load(3, 0, 1'b0);
        tick_cycle();
        check_output("masked_pulse", 32'(expired[3]), 32'h1);
        tick_cycle();
        check_output("masked_status", 32'(status), 32'h8);
        check_output("masked_irq", 32'(irq), 32'h0);
        irq_mask = '1;
        tick_cycle();
        check_output("unmasked_irq", 32'(irq), 32'h1);

        // Out-of-range loads, then N=0 periodic.
        load_valid = 1'b1; load_count = 16'd4; load_mode = 1'b1;
        load_channel = 3'd5; tick_cycle();
        load_channel = 3'd7; tick_cycle();
        load_valid = 1'b0;
        tick_cycle();
        check_output("out_of_range_ignored", 32'(running), 32'h0);
        pulse_load(4, 0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick_cycle();
            check_output("n0_periodic_every_cycle", 32'(expired[4]), 32'h1);
        end
        cancel[4] = 1'b1;
        tick_cycle();
        cancel = '0;
`else
        pulse_load(0, 2, 1'b0);
        measure(0, 30, at);
        check_output("prescale_latency_in_range", 32'(at >= 9 && at <= 15), 32'h1);
`endif

        // Reset mid-count.
        pulse_load(0, 20, 1'b0);
        status_clear = '0;
        for (int i = 0; i < 5; i++) tick_cycle();
        reset_n = 1'b0;
        tick_cycle();
        check_output("midreset_running", 32'(running), 32'h0);
        check_output("midreset_expired", 32'(expired), 32'h0);
        check_output("midreset_status",  32'(status),  32'h0);
        check_output("midreset_irq",     32'(irq),     32'h0);
        reset_n = 1'b1;

        for (int i = 0; i < 2000; i++) begin
            apply_stimulus();
            tick_cycle();
        end
        reset_n = 1'b1;
        idle_inputs();
        tick_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
